// File: rtl/seq_alu.sv
// seq_alu: registered 16-opcode ALU with valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, sel in;
//   out_valid/out_ready, out, hi, carry, ovf, zero, dz out.
//   mul/div iterate one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             dz
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  localparam int MSB = WIDTH - 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] WLIM = (WIDTH + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic             is_mul;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  // mul: {acc_hi, acc_lo} = partial product / remaining multiplier
  // div: acc_hi = partial remainder, acc_lo = dividend shifting into quotient
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_hi;
  logic             r_c;
  logic             r_v;
  logic             r_dz;
  logic             multi;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    r_out = '0;
    r_hi  = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_dz  = 1'b0;
    multi = (sel == OP_MUL) || ((sel == OP_DIV) && (b != '0));
    unique case (sel)
      OP_ADD: begin
        r_out = sum[MSB:0];
        r_c   = sum[WIDTH];
        r_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        r_out = dif[MSB:0];
        r_c   = dif[WIDTH];
        r_v   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      OP_MUL: ;
      // only reached single-cycle when b == 0
      OP_DIV: begin
        r_out = '1;
        r_hi  = a;
        r_dz  = 1'b1;
      end
      OP_SHL:  r_out = ({1'b0, b} >= WLIM) ? '0 : (a << b);
      OP_SHR:  r_out = ({1'b0, b} >= WLIM) ? '0 : (a >> b);
      OP_ROL:  r_out = {a[MSB-1:0], a[MSB]};
      OP_ROR:  r_out = {a[0], a[MSB:1]};
      OP_AND:  r_out = a & b;
      OP_OR:   r_out = a | b;
      OP_XOR:  r_out = a ^ b;
      OP_NOR:  r_out = ~(a | b);
      OP_NAND: r_out = ~(a & b);
      OP_XNOR: r_out = ~(a ^ b);
      OP_GT:   r_out = {{(WIDTH-1){1'b0}}, a > b};
      OP_EQ:   r_out = {{(WIDTH-1){1'b0}}, a == b};
    endcase
  end

  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH-1:0] nx_hi;
  logic [WIDTH-1:0] nx_lo;
  logic             last;

  always_comb begin
    madd = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
    rsh  = {acc_hi, acc_lo[MSB]};
    ge   = rsh >= {1'b0, opb};
    if (is_mul) begin
      nx_hi = madd[WIDTH:1];
      nx_lo = {madd[0], acc_lo[MSB:1]};
    end else begin
      // remainder after subtract is below opb, so WIDTH bits suffice
      nx_hi = ge ? (rsh[MSB:0] - opb) : rsh[MSB:0];
      nx_lo = {acc_lo[MSB-1:0], ge};
    end
    last = (cnt == LAST);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = multi ? BUSY : DONE;
      end
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_mul <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      out    <= '0;
      hi     <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          cnt    <= '0;
          is_mul <= (sel == OP_MUL);
          opa    <= a;
          opb    <= b;
          acc_hi <= '0;
          acc_lo <= (sel == OP_MUL) ? b : a;
          if (!multi) begin
            out   <= r_out;
            hi    <= r_hi;
            carry <= r_c;
            ovf   <= r_v;
            zero  <= (r_out == '0);
            dz    <= r_dz;
          end
        end
        BUSY: begin
          cnt    <= cnt + 1'b1;
          acc_hi <= nx_hi;
          acc_lo <= nx_lo;
          if (last) begin
            out   <= nx_lo;
            hi    <= nx_hi;
            carry <= 1'b0;
            ovf   <= 1'b0;
            zero  <= (nx_lo == '0);
            dz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. Supports the same 16 opcodes at any operand WIDTH and adds a valid/ready handshake on both sides, registered status flags, and a full-width high/remainder result. Multiply and divide run as iterative multi-cycle operations. It sits between an operand-issue stage and a result consumer in the datapath.

Parameters:
WIDTH, 8, operand and result width in bits (≥2)

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A (unsigned)
b  in  WIDTH  operand B (unsigned)
sel  in  4  opcode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  WIDTH  primary result
hi  out  WIDTH  product high half (mul), remainder (div), else 0
carry  out  1  carry out (add) / borrow (sub), else 0
ovf  out  1  signed overflow (add/sub), else 0
zero  out  1  out == 0
dz  out  1  divide by zero (div only)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: state IDLE; in_ready=1; out_valid=0; out, hi, carry, ovf, zero, dz all 0. rst overrides everything, including mid-operation; any partial mul/div result is discarded.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. a, b and sel are captured on that edge; later input changes have no effect.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of mul or div with b≠0.
  - IDLE → DONE on accept of div with b==0.
  - BUSY → DONE after exactly WIDTH iteration cycles.
  - DONE → IDLE on the edge where out_valid && out_ready.
- Handshake signals: in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Result hold: all result outputs stay stable while out_valid=1 and out_ready=0. A new operation cannot be accepted on the same edge a result retires; in_ready rises in the following cycle.
- Latency:
  - Single-cycle ops: out_valid asserts the cycle after the accept edge.
  - mul, and div with b≠0: out_valid asserts WIDTH+1 cycles after the accept edge.
- Opcodes (widths are WIDTH; results truncated to WIDTH unless noted):
  - 0000 add: out=a+b; carry=bit WIDTH of the sum; ovf=signed overflow.
  - 0001 sub: out=a-b mod 2^WIDTH; carry=(a<b) borrow; ovf=signed overflow.
  - 0010 mul: shift-add, one bit per cycle; {hi,out}=a*b (full 2·WIDTH product).
  - 0011 div: restoring, one quotient bit per cycle; out=a/b; hi=a%b. If b==0: out=all ones, hi=a, dz=1.
  - 0100 shl: out=a<<b. 0101 shr: out=a>>b (logical). Either gives 0 when b≥WIDTH.
  - 0110 rol / 0111 ror: rotate a by 1.
  - 1000–1101: and, or, xor, nor, nand, xnor.
  - 1110: out=(a>b)?1:0. 1111: out=(a==b)?1:0, zero-extended.
- Flags: zero is computed from out for every op. carry, ovf, dz are 0 where not defined above. hi=0 for all ops except mul/div.
- Input rules: in_valid while busy is ignored, not queued. The upstream stage must hold its inputs until in_ready.

Test Plan:
- Reset, then add a=200, b=100 (WIDTH=8) → next cycle out_valid=1, out=44, carry=1, ovf=0, zero=0.
- sub a=5, b=10 → out=251, carry=1; then sub a=127, b=255 (signed 127−(−1)) → out=128, ovf=1.
- mul a=200, b=3 → in_ready=0 for the busy period; out_valid exactly 9 cycles after accept; out=0x58, hi=0x02. Repeat with a=255, b=255 → out=0x01, hi=0xFE.
- div a=100, b=7 → out=14, hi=2 after 9 cycles. Then div a=0x55, b=0 → after 1 cycle out=0xFF, hi=0x55, dz=1.
- Backpressure: and a=0xF0, b=0x0F with out_ready low for 3 cycles → out=0x00, zero=1, result held stable, in_ready=0 throughout. Retire, then in_ready=1 on the next cycle. Also check shl a=1, b=9 → out=0.
- Assert rst 4 cycles into a div → next cycle IDLE, out_valid=0, all outputs 0. A following add 1+1 → out=2 after 1 cycle.
